tdm_demux16: RTL and testbench

TDM_DEMUX16 -- requirements
Module: tdm_demux16

---
 rtl/tdm_pkg.sv | 10 +
 rtl/demux1to16.sv | 15 +
 rtl/tdm_demux16.sv | 96 +++++++++
 tb/tb_tdm_demux16.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared constants and FSM encoding for the 16-channel TDM demultiplexer.
package tdm_pkg;
  localparam int unsigned NCH   = 16;
  localparam int unsigned SEL_W = 4;

  typedef enum logic {
    StHunt = 1'b0,
    StLock = 1'b1
  } state_e;
endpackage

// File: rtl/demux1to16.sv
// One-hot write-enable decode: exactly one bit of en_o is set when en is high.
module demux1to16
  import tdm_pkg::*;
(
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  output logic [NCH-1:0]   en_o
);

  always_comb begin
    en_o = '0;
    if (en) en_o[sel] = 1'b1;
  end

endmodule

// File: rtl/tdm_demux16.sv
// Serial 16-channel TDM demultiplexer: hunts for frame_sync, locks, and
// publishes each complete frame on q with a one-cycle frame_valid pulse.
module tdm_demux16
  import tdm_pkg::*;
#(
  parameter bit SYNC_CHECK = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [NCH-1:0]   q,
  output logic             frame_valid,
  output logic [SEL_W-1:0] ch,
  output logic             locked,
  output logic             sync_err
);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic [NCH-1:0]   shadow_q, shadow_d;
  logic [NCH-1:0]   wr_onehot;
  logic [SEL_W-1:0] wr_sel;
  logic             wr_en;
  logic             fv_d;
  logic             err_d;

  demux1to16 u_demux (
    .en   (wr_en),
    .sel  (wr_sel),
    .en_o (wr_onehot)
  );

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    wr_en   = 1'b0;
    wr_sel  = ch_q;
    fv_d    = 1'b0;
    err_d   = 1'b0;
    if (din_valid) begin
      unique case (state_q)
        StHunt: begin
          if (frame_sync) begin
            wr_en   = 1'b1;
            wr_sel  = '0;
            ch_d    = SEL_W'(1);
            state_d = StLock;
          end
        end
        StLock: begin
          if (frame_sync) begin
            // A sync away from channel 0 restarts the frame; stale shadow bits
            // are overwritten before the next channel-15 load.
            err_d  = (ch_q != '0);
            wr_en  = 1'b1;
            wr_sel = '0;
            ch_d   = SEL_W'(1);
          end else if ((ch_q == '0) && SYNC_CHECK) begin
            err_d   = 1'b1;
            state_d = StHunt;
          end else begin
            wr_en = 1'b1;
            ch_d  = ch_q + SEL_W'(1);
            fv_d  = (ch_q == SEL_W'(NCH - 1));
          end
        end
      endcase
    end
  end

  assign shadow_d = (shadow_q & ~wr_onehot) | ({NCH{din}} & wr_onehot);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StHunt;
      ch_q        <= '0;
      shadow_q    <= '0;
      q           <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      shadow_q    <= shadow_d;
      frame_valid <= fv_d;
      sync_err    <= err_d;
      if (fv_d) q <= {din, shadow_q[NCH-2:0]};
    end
  end

  assign ch     = ch_q;
  assign locked = (state_q == StLock);

endmodule

// File: tb/tb_tdm_demux16.sv
// Directed bench for tdm_demux16; a second instance covers SYNC_CHECK=0.
module tb_tdm_demux16;

  logic        clk = 1'b0;
  logic        rst;
  logic        din;
  logic        din_valid;
  logic        frame_sync;
  logic [15:0] q, q0;
  logic        fv, fv0, err, err0, locked, locked0;
  logic [3:0]  ch, ch0;

  int total = 0;
  int bad = 0;
  int fv_cnt = 0;
  int err_cnt = 0;
  int fv0_cnt = 0;
  int err0_cnt = 0;

  tdm_demux16 #(.SYNC_CHECK(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .frame_sync  (frame_sync),
    .q           (q),
    .frame_valid (fv),
    .ch          (ch),
    .locked      (locked),
    .sync_err    (err)
  );

  tdm_demux16 #(.SYNC_CHECK(1'b0)) dut0 (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .frame_sync  (frame_sync),
    .q           (q0),
    .frame_valid (fv0),
    .ch          (ch0),
    .locked      (locked0),
    .sync_err    (err0)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    fv_cnt   <= fv_cnt + int'(fv);
    err_cnt  <= err_cnt + int'(err);
    fv0_cnt  <= fv0_cnt + int'(fv0);
    err0_cnt <= err0_cnt + int'(err0);
  end

  task automatic beat(input logic d, input logic fs);
    @(negedge clk);
    din = d;
    frame_sync = fs;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    frame_sync = 1'b0;
    din = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] w, input int max_gap);
    for (int i = 0; i < 16; i++) begin
      beat(w[i], i == 0);
      if (max_gap > 0 && i < 15) idle(i % (max_gap + 1));
    end
  endtask

  task automatic test_reset();
    total++; if (q !== 16'h0000) begin bad++; $display("FAIL reset_q got=%h exp=0000", q); end
    total++; if (fv !== 1'b0) begin bad++; $display("FAIL reset_fv got=%b exp=0", fv); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%b exp=0", locked); end
    total++; if (ch !== 4'd0) begin bad++; $display("FAIL reset_ch got=%0d exp=0", ch); end
  endtask

  task automatic test_basic();
    int base;
    do_reset();
    base = fv_cnt;
    send_frame(16'hA5C3, 0);
    total++; if (q !== 16'hA5C3) begin bad++; $display("FAIL basic_q got=%h exp=a5c3", q); end
    total++; if (fv !== 1'b1) begin bad++; $display("FAIL basic_fv got=%b exp=1", fv); end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL basic_locked got=%b exp=1", locked); end
    total++; if (ch !== 4'd0) begin bad++; $display("FAIL basic_ch_wrap got=%0d exp=0", ch); end
    idle(1);
    total++; if (fv !== 1'b0) begin bad++; $display("FAIL basic_fv_one_cycle got=%b exp=0", fv); end
    idle(1);
    total++; if (fv_cnt - base != 1) begin bad++; $display("FAIL basic_fv_count got=%0d exp=1", fv_cnt - base); end
  endtask

  task automatic test_back_to_back();
    int base;
    logic [15:0] w;
    do_reset();
    base = fv_cnt;
    send_frame(16'h1234, 3);
    total++; if (q !== 16'h1234) begin bad++; $display("FAIL b2b_q1 got=%h exp=1234", q); end
    w = 16'hFFFF;
    for (int i = 0; i < 16; i++) begin
      beat(w[i], i == 0);
      if (i < 15) begin
        idle(i % 4);
        total++;
        if (q !== 16'h1234) begin bad++; $display("FAIL b2b_q_hold beat=%0d got=%h exp=1234", i, q); end
      end
    end
    total++; if (q !== 16'hFFFF) begin bad++; $display("FAIL b2b_q2 got=%h exp=ffff", q); end
    idle(3);
    total++; if (q !== 16'hFFFF) begin bad++; $display("FAIL b2b_q2_hold got=%h exp=ffff", q); end
    total++; if (fv_cnt - base != 2) begin bad++; $display("FAIL b2b_fv_count got=%0d exp=2", fv_cnt - base); end
  endtask

  task automatic test_hunt();
    int fbase, ebase;
    do_reset();
    fbase = fv_cnt;
    ebase = err_cnt;
    for (int i = 0; i < 8; i++) beat(1'b1, 1'b0);
    idle(1);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL hunt_locked got=%b exp=0", locked); end
    total++; if (ch !== 4'd0) begin bad++; $display("FAIL hunt_ch got=%0d exp=0", ch); end
    total++; if (q !== 16'h0000) begin bad++; $display("FAIL hunt_q got=%h exp=0000", q); end
    total++; if (fv_cnt != fbase) begin bad++; $display("FAIL hunt_fv_count got=%0d exp=%0d", fv_cnt, fbase); end
    total++; if (err_cnt != ebase) begin bad++; $display("FAIL hunt_err_count got=%0d exp=%0d", err_cnt, ebase); end
  endtask

  task automatic test_resync();
    int fbase, ebase;
    logic [15:0] w;
    do_reset();
    fbase = fv_cnt;
    ebase = err_cnt;
    for (int i = 0; i < 9; i++) beat(1'b1, i == 0);
    total++; if (ch !== 4'd9) begin bad++; $display("FAIL resync_ch_pre got=%0d exp=9", ch); end
    w = 16'h00FF;
    beat(w[0], 1'b1);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL resync_err got=%b exp=1", err); end
    total++; if (ch !== 4'd1) begin bad++; $display("FAIL resync_ch got=%0d exp=1", ch); end
    total++; if (fv !== 1'b0) begin bad++; $display("FAIL resync_fv got=%b exp=0", fv); end
    for (int i = 1; i < 16; i++) beat(w[i], 1'b0);
    total++; if (q !== 16'h00FF) begin bad++; $display("FAIL resync_q got=%h exp=00ff", q); end
    idle(2);
    total++; if (err_cnt - ebase != 1) begin bad++; $display("FAIL resync_err_count got=%0d exp=1", err_cnt - ebase); end
    total++; if (fv_cnt - fbase != 1) begin bad++; $display("FAIL resync_fv_count got=%0d exp=1", fv_cnt - fbase); end
  endtask

  task automatic test_missing_sync();
    int e0base;
    logic [15:0] w;
    do_reset();
    e0base = err0_cnt;
    send_frame(16'hBEEF, 0);
    w = 16'h5A5A;
    beat(w[0], 1'b0);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL nosync_err got=%b exp=1", err); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL nosync_locked got=%b exp=0", locked); end
    total++; if (locked0 !== 1'b1) begin bad++; $display("FAIL nosync_locked0 got=%b exp=1", locked0); end
    for (int i = 1; i < 16; i++) beat(w[i], 1'b0);
    total++; if (q !== 16'hBEEF) begin bad++; $display("FAIL nosync_q_keep got=%h exp=beef", q); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL nosync_locked_end got=%b exp=0", locked); end
    total++; if (q0 !== 16'h5A5A) begin bad++; $display("FAIL nosync_q0 got=%h exp=5a5a", q0); end
    total++; if (fv0 !== 1'b1) begin bad++; $display("FAIL nosync_fv0 got=%b exp=1", fv0); end
    idle(2);
    total++; if (err0_cnt != e0base) begin bad++; $display("FAIL nosync_err0_count got=%0d exp=%0d", err0_cnt, e0base); end
  endtask

  task automatic test_mid_reset();
    logic [15:0] w;
    do_reset();
    send_frame(16'hC0DE, 0);
    w = 16'h3C3C;
    for (int i = 0; i < 6; i++) beat(w[i], i == 0);
    total++; if (ch !== 4'd6) begin bad++; $display("FAIL midrst_ch_pre got=%0d exp=6", ch); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (q !== 16'h0000) begin bad++; $display("FAIL midrst_q got=%h exp=0000", q); end
    total++; if (ch !== 4'd0) begin bad++; $display("FAIL midrst_ch got=%0d exp=0", ch); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL midrst_locked got=%b exp=0", locked); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 6; i < 16; i++) beat(w[i], 1'b0);
    total++; if (q !== 16'h0000) begin bad++; $display("FAIL midrst_partial got=%h exp=0000", q); end
    send_frame(16'h3C3C, 1);
    total++; if (q !== 16'h3C3C) begin bad++; $display("FAIL midrst_q_after got=%h exp=3c3c", q); end
  endtask

  initial begin
    rst = 1'b1;
    din = 1'b0;
    din_valid = 1'b0;
    frame_sync = 1'b0;
    #2;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_basic();
    test_back_to_back();
    test_hunt();
    test_resync();
    test_missing_sync();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
